// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the RV32I core. Owns the PC, drives the
//   combinational instruction-memory address, and captures the returned
//   instruction (with its PC) into the IF/ID pipeline register. Handles
//   stall, control-flow redirect, misaligned-target trap and EBREAK halt.
//
// Ports
//   clk            core clock, all state updates on rising edge
//   rst            synchronous active-high reset
//   imem_addr      byte address to instruction memory (equals PC register)
//   imem_instr     instruction returned for imem_addr in the same cycle
//   stall          downstream not ready: hold PC and IF/ID register
//   redirect       taken branch/jump/trap-return from a later stage
//   redirect_pc    redirect target byte address
//   id_valid       IF/ID register holds a real instruction
//   id_instr       registered instruction
//   id_pc          registered PC of id_instr
//   id_misaligned  IF/ID entry is a misaligned-fetch trap marker
//   halted         fetch FSM is in HALTED
//   fetch_count    number of valid entries written to IF/ID
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_misaligned,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic        r_id_mis;
    logic [31:0] r_fetch_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_id_valid_nxt;
    logic [31:0] w_id_instr_nxt;
    logic [31:0] w_id_pc_nxt;
    logic        w_id_mis_nxt;
    logic [31:0] w_fetch_count_nxt;
    logic [31:0] w_target;

    // Bit 0 of a redirect target is always dropped; bit 1 flags a misaligned word fetch.
    assign w_target = {redirect_pc[31:1], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= '0;
            r_id_mis      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_instr    <= w_id_instr_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_mis      <= w_id_mis_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_id_valid_nxt    = r_id_valid;
        w_id_instr_nxt    = r_id_instr;
        w_id_pc_nxt       = r_id_pc;
        w_id_mis_nxt      = r_id_mis;
        w_fetch_count_nxt = r_fetch_count;

        if (redirect) begin
            // Redirect overrides stall; a misaligned target still lands its trap marker.
            w_pc_nxt       = w_target;
            w_id_valid_nxt = 1'b0;
            w_id_instr_nxt = NOP_INSTR;
            w_id_mis_nxt   = 1'b0;
            w_state_nxt    = RUN;
            if (w_target[1]) begin
                w_state_nxt       = HALTED;
                w_id_valid_nxt    = 1'b1;
                w_id_mis_nxt      = 1'b1;
                w_id_pc_nxt       = w_target;
                w_fetch_count_nxt = r_fetch_count + 32'd1;
            end
        end else if (!stall) begin
            unique case (r_state)
                RUN: begin
                    w_id_instr_nxt    = imem_instr;
                    w_id_pc_nxt       = r_pc;
                    w_id_valid_nxt    = 1'b1;
                    w_id_mis_nxt      = 1'b0;
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                    if (imem_instr == EBREAK_INSTR) begin
                        w_state_nxt = HALTED;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
                HALTED: begin
                    w_id_valid_nxt = 1'b0;
                    w_id_instr_nxt = NOP_INSTR;
                    w_id_mis_nxt   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr     = r_pc;
    assign id_valid      = r_id_valid;
    assign id_instr      = r_id_instr;
    assign id_pc         = r_id_pc;
    assign id_misaligned = r_id_mis;
    assign halted        = (r_state == HALTED);
    assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_misaligned;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_idpc = '0;
    logic        m_mis = 1'b0;
    logic        m_halt = 1'b0;
    logic [31:0] m_cnt = '0;

    assign imem_instr = mem[imem_addr[7:2]];

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INSTR(NOP),
        .EBREAK_INSTR(EBREAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_instr(id_instr),
        .id_pc(id_pc),
        .id_misaligned(id_misaligned),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    // Behavioural model of one clock edge, written straight from the fetch rules.
    task automatic model_step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
        logic [31:0] t;
        logic [31:0] ins;
        ins = mem[m_pc[7:2]];
        t = rp & ~32'd1;
        if (r) begin
            m_pc = 32'h0; m_valid = 0; m_instr = NOP; m_idpc = 0; m_mis = 0; m_halt = 0; m_cnt = 0;
        end else if (rd) begin
            m_pc = t; m_valid = 0; m_instr = NOP; m_mis = 0; m_halt = 0;
            if (t % 4 != 0) begin
                m_halt = 1; m_valid = 1; m_mis = 1; m_idpc = t; m_cnt = m_cnt + 1;
            end
        end else if (s) begin
            // everything holds
        end else if (!m_halt) begin
            m_idpc = m_pc; m_instr = ins; m_valid = 1; m_mis = 0; m_cnt = m_cnt + 1;
            if (ins == EBREAK) m_halt = 1;
            else m_pc = m_pc + 4;
        end else begin
            m_valid = 0; m_instr = NOP; m_mis = 0;
        end
    endtask

    task automatic tick();
        model_step(rst, stall, redirect, redirect_pc);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [131:0] dut_vec();
        return {imem_addr, id_valid, id_instr, id_pc, id_misaligned, halted, fetch_count};
    endfunction

    function automatic logic [131:0] mdl_vec();
        return {m_pc, m_valid, m_instr, m_idpc, m_mis, m_halt, m_cnt};
    endfunction

    task automatic test_reset();
        rst = 1; stall = 0; redirect = 0;
        tick(); tick();
        vectors++;
        if ({imem_addr, id_valid, id_instr, id_pc, id_misaligned, halted, fetch_count}
            !== {32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset: got %h expected %h", dut_vec(),
                     {32'h0, 1'b0, NOP, 32'h0, 1'b0, 1'b0, 32'h0});
        end
        rst = 0;
    endtask

    task automatic test_straight_line();
        logic [31:0] prog [4];
        prog = '{32'h0010_0093, 32'h0020_0093, 32'h0040_0093, 32'hFF5F_F06F};
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({id_valid, id_pc, id_instr, fetch_count, id_misaligned}
                !== {1'b1, 32'(4 * i), prog[i], 32'(i + 1), 1'b0}) begin
                miscompares++;
                $display("FAIL straight[%0d]: got v=%b pc=%h ins=%h cnt=%0d mis=%b expected pc=%h ins=%h cnt=%0d",
                         i, id_valid, id_pc, id_instr, fetch_count, id_misaligned, 4 * i, prog[i], i + 1);
            end
        end
        vectors++;
        if (imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL straight_pc: got %h expected 00000010", imem_addr);
        end
    endtask

    task automatic test_redirect();
        redirect = 1; redirect_pc = 32'h0;
        tick();
        redirect = 0;
        vectors++;
        if ({id_valid, fetch_count, imem_addr} !== {1'b0, 32'd4, 32'h0}) begin
            miscompares++;
            $display("FAIL redirect_bubble: got v=%b cnt=%0d addr=%h expected v=0 cnt=4 addr=0",
                     id_valid, fetch_count, imem_addr);
        end
        tick();
        vectors++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, 32'h0010_0093}) begin
            miscompares++;
            $display("FAIL redirect_refetch: got v=%b pc=%h ins=%h expected v=1 pc=0 ins=00100093",
                     id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_stall();
        tick();                          // fetch pc 4, pc -> 8
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({imem_addr, id_valid, id_pc, id_instr, fetch_count}
                !== {32'h8, 1'b1, 32'h4, 32'h0020_0093, 32'd6}) begin
                miscompares++;
                $display("FAIL stall[%0d]: got addr=%h v=%b pc=%h ins=%h cnt=%0d expected addr=8 v=1 pc=4 ins=00200093 cnt=6",
                         i, imem_addr, id_valid, id_pc, id_instr, fetch_count);
            end
        end
        redirect = 1; redirect_pc = 32'h20;
        tick();
        redirect = 0; stall = 0;
        vectors++;
        if ({id_valid, imem_addr, fetch_count} !== {1'b0, 32'h20, 32'd6}) begin
            miscompares++;
            $display("FAIL stall_redirect: got v=%b addr=%h cnt=%0d expected v=0 addr=00000020 cnt=6",
                     id_valid, imem_addr, fetch_count);
        end
    endtask

    task automatic test_misaligned();
        redirect = 1; redirect_pc = 32'h7;
        tick();
        redirect = 0;
        vectors++;
        if ({id_valid, id_misaligned, id_pc, id_instr, halted, fetch_count}
            !== {1'b1, 1'b1, 32'h6, NOP, 1'b1, 32'd7}) begin
            miscompares++;
            $display("FAIL misaligned_marker: got v=%b mis=%b pc=%h ins=%h halt=%b cnt=%0d expected 1 1 6 00000013 1 7",
                     id_valid, id_misaligned, id_pc, id_instr, halted, fetch_count);
        end
        tick();
        vectors++;
        if ({id_valid, id_misaligned, imem_addr, halted} !== {1'b0, 1'b0, 32'h6, 1'b1}) begin
            miscompares++;
            $display("FAIL misaligned_drain: got v=%b mis=%b addr=%h halt=%b expected 0 0 6 1",
                     id_valid, id_misaligned, imem_addr, halted);
        end
        stall = 1; redirect = 1; redirect_pc = 32'h0000_000B;
        tick();
        stall = 0; redirect = 0;
        vectors++;
        if ({id_valid, id_misaligned, id_pc, fetch_count} !== {1'b1, 1'b1, 32'hA, 32'd8}) begin
            miscompares++;
            $display("FAIL misaligned_stalled: got v=%b mis=%b pc=%h cnt=%0d expected 1 1 a 8",
                     id_valid, id_misaligned, id_pc, fetch_count);
        end
    endtask

    task automatic test_ebreak();
        mem[2] = EBREAK;
        redirect = 1; redirect_pc = 32'h0;
        tick();
        redirect = 0;
        tick(); tick(); tick();
        vectors++;
        if ({id_valid, id_pc, id_instr, halted, imem_addr} !== {1'b1, 32'h8, EBREAK, 1'b1, 32'h8}) begin
            miscompares++;
            $display("FAIL ebreak_entry: got v=%b pc=%h ins=%h halt=%b addr=%h expected 1 8 00100073 1 8",
                     id_valid, id_pc, id_instr, halted, imem_addr);
        end
        tick();
        vectors++;
        if ({id_valid, id_instr, halted, imem_addr} !== {1'b0, NOP, 1'b1, 32'h8}) begin
            miscompares++;
            $display("FAIL ebreak_drain: got v=%b ins=%h halt=%b addr=%h expected 0 00000013 1 8",
                     id_valid, id_instr, halted, imem_addr);
        end
        redirect = 1; redirect_pc = 32'h0;
        tick();
        redirect = 0;
        tick();
        vectors++;
        if ({halted, id_valid, id_pc, imem_addr} !== {1'b0, 1'b1, 32'h0, 32'h4}) begin
            miscompares++;
            $display("FAIL ebreak_resume: got halt=%b v=%b pc=%h addr=%h expected 0 1 0 4",
                     halted, id_valid, id_pc, imem_addr);
        end
        mem[2] = 32'h0040_0093;
    endtask

    task automatic test_reset_mid();
        rst = 1; tick(); rst = 0;
        mem[4] = EBREAK;
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if ({halted, fetch_count, id_pc} !== {1'b1, 32'd5, 32'h10}) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got halt=%b cnt=%0d pc=%h expected 1 5 10",
                     halted, fetch_count, id_pc);
        end
        stall = 1; rst = 1;
        tick();
        rst = 0; stall = 0;
        vectors++;
        if ({imem_addr, id_valid, id_instr, id_pc, halted, fetch_count}
            !== {32'h0, 1'b0, NOP, 32'h0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_mid: got addr=%h v=%b ins=%h pc=%h halt=%b cnt=%0d expected reset values",
                     imem_addr, id_valid, id_instr, id_pc, halted, fetch_count);
        end
        mem[4] = NOP;
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? EBREAK : $urandom();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = $urandom();
                1: redirect_pc = 32'hFFFF_FFF8;
                default: redirect_pc = {24'h0, 6'($urandom()), 2'b00};
            endcase
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        rst = 0; stall = 0; redirect = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = NOP;
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0020_0093;
        mem[2] = 32'h0040_0093;
        mem[3] = 32'hFF5F_F06F;
        test_reset();
        test_straight_line();
        test_redirect();
        test_stall();
        test_misaligned();
        test_ebreak();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core; sits directly upstream of the combinational word-addressed instruction memory.
- Owns the PC and drives the memory address each cycle.
- Captures the returned instruction, with its PC, into the IF/ID pipeline register.
- Handles stall, control-flow redirect, misaligned-target trap and EBREAK halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013, encoding placed in id_instr for bubbles and traps (addi x0,x0,0).
- EBREAK_INSTR, 32'h0010_0073, encoding that halts fetch.

Ports:
- clk  input  1  single core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals pc register, combinational.
- imem_instr  input  32  instruction returned combinationally for imem_addr in the same cycle.
- stall  input  1  downstream not ready; hold PC and IF/ID register.
- redirect  input  1  taken branch/jump/trap-return from later stage.
- redirect_pc  input  32  target byte address for redirect.
- id_valid  output  1  IF/ID register holds a real instruction.
- id_instr  output  32  registered instruction.
- id_pc  output  32  registered PC of id_instr.
- id_misaligned  output  1  id entry is a misaligned-fetch trap marker.
- halted  output  1  fetch is in HALTED state.
- fetch_count  output  32  number of valid entries written to IF/ID.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: pc=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_misaligned=0, state=RUN, halted=0, fetch_count=0.
- Latency: instruction at pc appears on id_* the cycle after imem_addr=pc (one register stage).
- Priority per edge: rst > redirect > stall > normal advance.
- FSM has two states, RUN and HALTED; halted=1 exactly when state=HALTED.
- RUN, no stall, no redirect:
  - id_instr<=imem_instr, id_pc<=pc, id_valid<=1, id_misaligned<=0, pc<=pc+4 (mod 2^32, wraps silently), fetch_count++.
  - If imem_instr==EBREAK_INSTR, the EBREAK is still written valid, state<=HALTED, and pc holds.
- Stall without redirect: pc, all id_* and fetch_count hold; imem_addr stays constant.
- Redirect (any state, regardless of stall): id_valid<=0, id_instr<=NOP_INSTR, id_misaligned<=0, fetch_count unchanged, state<=RUN.
  - Target t = {redirect_pc[31:1],1'b0}; bit0 is always cleared.
  - If t[1]==0: pc<=t.
  - If t[1]==1: pc<=t, state<=HALTED, and a trap marker is written: id_valid<=1, id_misaligned<=1, id_instr<=NOP_INSTR, id_pc<=t, fetch_count++. The marker is written even if stall is high.
- HALTED, no redirect:
  - If not stalled, the IF/ID register drains to a bubble: id_valid<=0, id_instr<=NOP_INSTR, id_misaligned<=0.
  - pc holds and imem_instr is ignored.
  - Exit from HALTED only by redirect (aligned target resumes RUN) or rst.
- fetch_count wraps 32'hFFFF_FFFF -> 0.
- Reset asserted mid-stall, mid-halt or coincident with redirect: reset wins and all values return to reset values the next cycle.
- No combinational path from stall or redirect to imem_addr.

Test Plan:
- Straight-line fetch: rst high 2 cycles, then 4 cycles with mem[0..3]={00100093,00200093,00400093,FF5FF06F} -> id_pc 0,4,8,C with matching id_instr, id_valid=1, fetch_count=4.
- Redirect: when pc=0x10, pulse redirect with redirect_pc=0 -> next cycle id_valid=0 and fetch_count unchanged; following cycle id_pc=0, id_instr=00100093.
- Stall and stall+redirect: stall 3 cycles at pc=8 -> imem_addr=8 and id_* frozen. Then assert stall and redirect_pc=0x20 together -> id_valid=0, next imem_addr=0x20.
- Misaligned target: redirect_pc=0x0000_0007 -> id_valid=1, id_misaligned=1, id_pc=6, id_instr=00000013, halted=1; next cycle id_valid=0, and pc stays 6 with no stall.
- EBREAK halt and resume: mem[2]=00100073 -> id entry at pc 8 valid, halted=1, imem_addr stays 8, id_valid=0 after. Redirect to 0 -> halted=0, fetch resumes at 0.
- Reset mid-operation: assert rst while halted with fetch_count=5 -> next cycle pc=RESET_PC, id_valid=0, fetch_count=0, halted=0.
